// File: rtl/rep_string_seq.sv
// rep_string_seq: sequences 8086 string instructions (MOVS/STOS/LODS/CMPS/SCAS),
// optionally REP-prefixed. Issues memory phases, steps SI/DI, decrements CX
// and evaluates the REP/REPE/REPNE exit conditions including interrupt break-out.
module rep_string_seq #(
  parameter logic [3:0] SI_ADDR = 4'd6,
  parameter logic [3:0] DI_ADDR = 4'd7,
  parameter logic [3:0] CX_ADDR = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [1:0]  rep,
  input  logic        word_op,
  input  logic        df,
  input  logic [15:0] si,
  input  logic [15:0] di,
  input  logic [15:0] cx,
  input  logic        cx_zero,
  input  logic        zf,
  input  logic        intr_pending,
  output logic        mem_stb,
  output logic [1:0]  mem_kind,
  input  logic        mem_ack,
  output logic        rf_wr,
  output logic [3:0]  rf_addr_d,
  output logic [15:0] rf_d,
  output logic        busy,
  output logic        done,
  output logic        intr_break
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_UPD_SI = 3'd3;
  localparam logic [2:0] S_UPD_DI = 3'd4;
  localparam logic [2:0] S_UPD_CX = 3'd5;
  localparam logic [2:0] S_TEST   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [2:0] OP_MOVS = 3'd0;
  localparam logic [2:0] OP_STOS = 3'd1;
  localparam logic [2:0] OP_LODS = 3'd2;
  localparam logic [2:0] OP_CMPS = 3'd3;
  localparam logic [2:0] OP_SCAS = 3'd4;

  localparam logic [1:0] K_RD_SI = 2'd0;
  localparam logic [1:0] K_RD_DI = 2'd1;
  localparam logic [1:0] K_WR_DI = 2'd2;

  logic [2:0]  state, state_nx;
  logic [2:0]  op_q;
  logic [1:0]  rep_q;
  logic        word_q, df_q;
  logic        phase_q;
  logic        brk_q;

  logic [2:0]  op_n;
  logic [1:0]  rep_n;
  logic        uses_si, uses_di, two_phase, is_cmp, rep_on, term_zf;
  logic        last_phase, take_intr;
  logic [15:0] step;
  logic [1:0]  kind;

  // Normalise the raw decode fields before latching them.
  always_comb begin
    op_n  = (op > OP_SCAS) ? OP_STOS : op;
    rep_n = (rep == 2'd3) ? 2'd0 : rep;
  end

  // Per-instruction attributes derived from the latched op/rep/size/direction.
  always_comb begin
    uses_si    = (op_q == OP_MOVS) || (op_q == OP_LODS) || (op_q == OP_CMPS);
    uses_di    = (op_q != OP_LODS);
    two_phase  = (op_q == OP_MOVS) || (op_q == OP_CMPS);
    is_cmp     = (op_q == OP_CMPS) || (op_q == OP_SCAS);
    rep_on     = (rep_q != 2'd0);
    term_zf    = is_cmp && (((rep_q == 2'd1) && !zf) || ((rep_q == 2'd2) && zf));
    last_phase = !two_phase || phase_q;
    take_intr  = rep_on && !cx_zero && !term_zf && intr_pending;
    if (df_q) step = word_q ? 16'hFFFE : 16'hFFFF;
    else      step = word_q ? 16'h0002 : 16'h0001;
    case (op_q)
      OP_MOVS: kind = phase_q ? K_WR_DI : K_RD_SI;
      OP_LODS: kind = K_RD_SI;
      OP_CMPS: kind = phase_q ? K_RD_DI : K_RD_SI;
      OP_SCAS: kind = K_RD_DI;
      default: kind = K_WR_DI;
    endcase
  end

  // Next-state selection for the iteration loop.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (rep_n != 2'd0) ? S_CHECK : S_MEM;
      S_CHECK:  state_nx = cx_zero ? S_DONE : S_MEM;
      S_MEM:    if (mem_ack && last_phase) state_nx = uses_si ? S_UPD_SI : S_UPD_DI;
      S_UPD_SI: state_nx = uses_di ? S_UPD_DI : (rep_on ? S_UPD_CX : S_TEST);
      S_UPD_DI: state_nx = rep_on ? S_UPD_CX : S_TEST;
      S_UPD_CX: state_nx = S_TEST;
      S_TEST:   state_nx = (!rep_on || cx_zero || term_zf || intr_pending) ? S_DONE : S_MEM;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register plus latched instruction fields, phase and break flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rep_q   <= '0;
      word_q  <= 1'b0;
      df_q    <= 1'b0;
      phase_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q    <= op_n;
        rep_q   <= rep_n;
        word_q  <= word_op;
        df_q    <= df;
        phase_q <= 1'b0;
        brk_q   <= 1'b0;
      end
      if (state == S_MEM && mem_ack) phase_q <= two_phase && !phase_q;
      if (state == S_TEST) brk_q <= take_intr;
    end
  end

  // Outputs decode directly from state so reset clears them without a clock.
  always_comb begin
    mem_stb    = (state == S_MEM);
    mem_kind   = mem_stb ? kind : 2'd0;
    rf_wr      = 1'b0;
    rf_addr_d  = '0;
    rf_d       = '0;
    case (state)
      S_UPD_SI: begin rf_wr = 1'b1; rf_addr_d = SI_ADDR; rf_d = si + step;  end
      S_UPD_DI: begin rf_wr = 1'b1; rf_addr_d = DI_ADDR; rf_d = di + step;  end
      S_UPD_CX: begin rf_wr = 1'b1; rf_addr_d = CX_ADDR; rf_d = cx - 16'd1; end
      default: ;
    endcase
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    intr_break = done && brk_q;
  end

endmodule

// File: tb/tb_rep_string_seq.sv
// Directed bench for rep_string_seq with a small register-file and memory responder model.
module tb_rep_string_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  rep = '0;
  logic        word_op = 1'b0;
  logic        df = 1'b0;
  logic        zf;
  logic        intr_pending = 1'b0;
  logic        cx_zero;
  logic        mem_stb, mem_ack, rf_wr, busy, done, intr_break;
  logic [1:0]  mem_kind;
  logic [3:0]  rf_addr_d;
  logic [15:0] rf_d;

  logic [15:0] m_si = '0, m_di = '0, m_cx = '0;
  logic [15:0] ld_si = '0, ld_di = '0, ld_cx = '0;
  logic        clr = 1'b0;
  logic        ack_en = 1'b1;
  logic        zf_mode = 1'b0;
  int          cyc = 0;
  int          n_mem = 0, n_rf = 0, n_cxw = 0, n_done = 0, n_brk = 0, n_brk_alone = 0;
  int          done_cyc = 0, di_wr_cyc = 0;
  logic [15:0] di_wr_val = '0;
  logic [15:0] kinds = '0;

  int          errs = 0;
  int          checks = 0;
  int          s_cyc = 0;

  assign cx_zero = (m_cx == 16'd0);
  assign mem_ack = ack_en && mem_stb;
  assign zf      = zf_mode ? (n_cxw < 2) : 1'b0;

  rep_string_seq #(.SI_ADDR(4'd6), .DI_ADDR(4'd7), .CX_ADDR(4'd1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rep(rep), .word_op(word_op),
    .df(df), .si(m_si), .di(m_di), .cx(m_cx), .cx_zero(cx_zero), .zf(zf),
    .intr_pending(intr_pending), .mem_stb(mem_stb), .mem_kind(mem_kind),
    .mem_ack(mem_ack), .rf_wr(rf_wr), .rf_addr_d(rf_addr_d), .rf_d(rf_d),
    .busy(busy), .done(done), .intr_break(intr_break)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model and event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr) begin
      m_si <= ld_si; m_di <= ld_di; m_cx <= ld_cx;
      n_mem <= 0; n_rf <= 0; n_cxw <= 0; n_done <= 0; n_brk <= 0; n_brk_alone <= 0;
      done_cyc <= 0; di_wr_cyc <= 0; di_wr_val <= '0; kinds <= '0;
    end else begin
      if (rf_wr) begin
        n_rf <= n_rf + 1;
        case (rf_addr_d)
          4'd6: m_si <= rf_d;
          4'd7: begin m_di <= rf_d; di_wr_cyc <= cyc; di_wr_val <= rf_d; end
          4'd1: begin m_cx <= rf_d; n_cxw <= n_cxw + 1; end
          default: ;
        endcase
      end
      if (mem_stb && mem_ack) begin
        n_mem <= n_mem + 1;
        kinds <= {kinds[13:0], mem_kind};
      end
      if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (intr_break) n_brk <= n_brk + 1;
      if (intr_break && !done) n_brk_alone <= n_brk_alone + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    @(negedge clk);
    ld_si = s; ld_di = d; ld_cx = c; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [1:0] r, input logic w, input logic d);
    int t;
    @(negedge clk);
    op = o; rep = r; word_op = w; df = d; start = 1'b1; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (n_done == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (n_done == 0) begin
      checks++; errs++;
      $error("FAIL timeout: observed=no done expected=done within 300 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_mem_stb", mem_stb, 0);
    check("rst_rf_wr", rf_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_brk", intr_break, 0);
    check("rst_kind", mem_kind, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // STOS byte, no rep, df=0, di=0x0010: latency and single DI write
    load(16'h0100, 16'h0010, 16'h0005);
    run(3'd1, 2'd0, 1'b0, 1'b0);
    check("stos_mem", n_mem, 1);
    check("stos_kind", kinds, 16'h0002);
    check("stos_rf", n_rf, 1);
    check("stos_di", m_di, 16'h0011);
    check("stos_di_cyc", di_wr_cyc - s_cyc, 2);
    check("stos_done_cyc", done_cyc - s_cyc, 4);
    check("stos_cx", m_cx, 16'h0005);
    check("stos_busy_after", busy, 0);

    // op=7/rep=3 behave as plain STOS; DI wraps FFFF->0000
    load(16'h0000, 16'hFFFF, 16'h0003);
    run(3'd7, 2'd3, 1'b0, 1'b0);
    check("op7_kind", kinds, 16'h0002);
    check("op7_di_wrap", m_di, 16'h0000);
    check("op7_cx", m_cx, 16'h0003);

    // REP MOVS word df=1, cx=3: SI wraps 0004->FFFE, DI 0006->0000
    load(16'h0004, 16'h0006, 16'h0003);
    run(3'd0, 2'd1, 1'b1, 1'b1);
    check("movs_si", m_si, 16'hFFFE);
    check("movs_di", m_di, 16'h0000);
    check("movs_cx", m_cx, 16'h0000);
    check("movs_mem", n_mem, 6);
    check("movs_kinds", kinds, 16'h0222);
    check("movs_rf", n_rf, 9);
    check("movs_done_cyc", done_cyc - s_cyc, 20);
    check("movs_done_cnt", n_done, 1);
    check("movs_brk", n_brk, 0);

    // REP STOS with cx=0: nothing happens, done two cycles after start
    load(16'h0000, 16'h0040, 16'h0000);
    run(3'd1, 2'd1, 1'b0, 1'b0);
    check("zero_mem", n_mem, 0);
    check("zero_rf", n_rf, 0);
    check("zero_done_cyc", done_cyc - s_cyc, 2);

    // REPE CMPS byte cx=5, zf drops on the 2nd compare
    zf_mode = 1'b1;
    load(16'h1000, 16'h2000, 16'h0005);
    run(3'd3, 2'd1, 1'b0, 1'b0);
    zf_mode = 1'b0;
    check("cmps_cx", m_cx, 16'h0003);
    check("cmps_si", m_si, 16'h1002);
    check("cmps_di", m_di, 16'h2002);
    check("cmps_kinds", kinds, 16'h0011);
    check("cmps_brk", n_brk, 0);

    // REPNE SCAS with zf=0 keeps going until CX runs out
    load(16'h0000, 16'h0300, 16'h0002);
    run(3'd4, 2'd2, 1'b1, 1'b0);
    check("scas_cx", m_cx, 16'h0000);
    check("scas_di", m_di, 16'h0304);
    check("scas_kinds", kinds, 16'h0005);

    // REP LODS cx=4 with interrupt pending: break after one iteration
    intr_pending = 1'b1;
    load(16'h0050, 16'h0000, 16'h0004);
    run(3'd2, 2'd1, 1'b0, 1'b0);
    check("lods_int_cx", m_cx, 16'h0003);
    check("lods_int_si", m_si, 16'h0051);
    check("lods_int_brk", n_brk, 1);
    check("lods_int_brk_alone", n_brk_alone, 0);
    check("lods_int_done", n_done, 1);

    // same with cx=1: termination beats interrupt
    load(16'h0050, 16'h0000, 16'h0001);
    run(3'd2, 2'd1, 1'b0, 1'b0);
    intr_pending = 1'b0;
    check("lods_last_cx", m_cx, 16'h0000);
    check("lods_last_brk", n_brk, 0);
    check("lods_last_done", n_done, 1);

    // asynchronous reset while a phase is stalled
    load(16'h0000, 16'h0080, 16'h0000);
    ack_en = 1'b0;
    @(negedge clk);
    op = 3'd1; rep = 2'd0; word_op = 1'b0; df = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("stall_stb", mem_stb, 1);
    check("stall_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_stb", mem_stb, 0);
    check("async_busy", busy, 0);
    check("async_rf", rf_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    check("async_no_write", m_di, 16'h0080);

    load(16'h0000, 16'h0080, 16'h0000);
    run(3'd1, 2'd0, 1'b1, 1'b0);
    check("post_rst_di", m_di, 16'h0082);
    check("post_rst_done_cyc", done_cyc - s_cyc, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
